// File: rtl/switchbox_cfg_loader.sv
// Serial configuration loader for the switch-box routing matrix: hunts for a sync byte,
// shifts in 18 six-bit route words plus a checksum, and commits them atomically when valid.
module switchbox_cfg_loader #(
  parameter logic [7:0] SYNC_PATTERN   = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 64,
  localparam int        NWORDS         = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic                  cfg_bit,
  output logic [6*NWORDS-1:0]   cfg_words,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [1:0]            err_code,
  output logic [1:0]            dbg_state
);

  // Handshake: cfg_en is a valid-only qualifier with no ready. Every cycle with cfg_en high
  // delivers one cfg_bit; the only state that drops a delivered bit is COMMIT.

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [7:0]           window;
  logic [2:0]           bit_in_word;
  logic [4:0]           word_idx;
  logic [5:0]           word_sr;
  logic [6*NWORDS-1:0]  shadow;
  logic [7:0]           sum;
  logic                 range_flag;
  logic [7:0]           chk_sr;
  logic [2:0]           chk_cnt;
  logic [IW-1:0]        idle_cnt;

  logic [7:0]           window_n;
  logic [5:0]           word_n;
  logic [7:0]           chk_n;
  logic                 word_end;
  logic                 last_payload;
  logic                 idle_limit;
  logic                 word_bad;
  logic                 sync_hit;
  logic                 fail_sum;
  logic                 fail_rng;
  logic                 fail_tmo;

  // Legal index range depends on the side the word routes from.
  function automatic logic out_of_range(input logic [5:0] w);
    logic bad;
    case (w[2:0])
      3'd0:       bad = 1'b0;
      3'd1, 3'd3: bad = (w[5:3] > 3'd4);
      3'd2, 3'd4: bad = (w[5:3] > 3'd3);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign window_n     = {window[6:0], cfg_bit};
  assign word_n       = {cfg_bit, word_sr[5:1]};
  assign chk_n        = {cfg_bit, chk_sr[7:1]};
  assign word_end     = (bit_in_word == 3'd5);
  assign last_payload = word_end && (word_idx == 5'(NWORDS - 1));
  assign idle_limit   = !cfg_en && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
  assign word_bad     = out_of_range(word_n);

  assign busy      = (state != HUNT);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    sync_hit = 1'b0;
    fail_sum = 1'b0;
    fail_rng = 1'b0;
    fail_tmo = 1'b0;
    case (state)
      HUNT: begin
        if (cfg_en && (window_n == SYNC_PATTERN)) begin
          sync_hit = 1'b1;
          state_n  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (cfg_en) begin
          if (last_payload) begin
            state_n = CHECK;
          end
        end else if (idle_limit) begin
          fail_tmo = 1'b1;
          state_n  = HUNT;
        end
      end
      CHECK: begin
        if (cfg_en) begin
          if (chk_cnt == 3'd7) begin
            // Checksum mismatch takes priority over a range violation.
            if (chk_n != sum) begin
              fail_sum = 1'b1;
            end else if (range_flag) begin
              fail_rng = 1'b1;
            end
            state_n = (fail_sum || fail_rng) ? HUNT : COMMIT;
          end
        end else if (idle_limit) begin
          fail_tmo = 1'b1;
          state_n  = HUNT;
        end
      end
      COMMIT: begin
        state_n = HUNT;
      end
      default: begin
        state_n = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window      <= '0;
      bit_in_word <= '0;
      word_idx    <= '0;
      word_sr     <= '0;
      shadow      <= '0;
      sum         <= '0;
      range_flag  <= 1'b0;
      chk_sr      <= '0;
      chk_cnt     <= '0;
      idle_cnt    <= '0;
      cfg_words   <= '0;
      cfg_valid   <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        HUNT: begin
          if (cfg_en) begin
            window <= window_n;
          end
          if (sync_hit) begin
            bit_in_word <= '0;
            word_idx    <= '0;
            sum         <= '0;
            range_flag  <= 1'b0;
            chk_cnt     <= '0;
            idle_cnt    <= '0;
          end
        end
        PAYLOAD: begin
          if (cfg_en) begin
            idle_cnt <= '0;
            word_sr  <= word_n;
            if (word_end) begin
              for (int k = 0; k < NWORDS; k++) begin
                if (word_idx == 5'(k)) begin
                  shadow[6*k +: 6] <= word_n;
                end
              end
              sum         <= sum + {2'b00, word_n};
              range_flag  <= range_flag | word_bad;
              bit_in_word <= '0;
              word_idx    <= word_idx + 5'd1;
            end else begin
              bit_in_word <= bit_in_word + 3'd1;
            end
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (cfg_en) begin
            idle_cnt <= '0;
            chk_sr   <= chk_n;
            chk_cnt  <= chk_cnt + 3'd1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        COMMIT: begin
          cfg_words <= shadow;
          cfg_valid <= 1'b1;
          cfg_done  <= 1'b1;
          err_code  <= 2'd0;
        end
        default: begin
        end
      endcase

      if (fail_sum) begin
        cfg_err  <= 1'b1;
        err_code <= 2'd1;
      end else if (fail_rng) begin
        cfg_err  <= 1'b1;
        err_code <= 2'd2;
      end else if (fail_tmo) begin
        cfg_err  <= 1'b1;
        err_code <= 2'd3;
      end

      // A fresh hunt never matches on bits left over from the previous frame.
      if ((state != HUNT) && (state_n == HUNT)) begin
        window <= '0;
      end
    end
  end

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Self-checking bench for switchbox_cfg_loader: frames are driven bit-serially, the expected
// commit/error event is queued at the last bit and compared when the DUT pulses done or err.
module tb_switchbox_cfg_loader;

  localparam int EW = 117;  // {latency[3:0], valid, kind[1:0], code[1:0], words[107:0]}

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_en;
  logic         cfg_bit;
  logic [107:0] cfg_words;
  logic         cfg_valid;
  logic         busy;
  logic         cfg_done;
  logic         cfg_err;
  logic [1:0]   err_code;
  logic [1:0]   dbg_state;

  switchbox_cfg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (cfg_en),
    .cfg_bit   (cfg_bit),
    .cfg_words (cfg_words),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [107:0] mdl_words;
  logic         mdl_valid;
  int unsigned  last_bit_cyc;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (cfg_done || cfg_err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {cfg_done, cfg_err}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("evt_kind", {cfg_done, cfg_err}, mon_e[111:110]);
        check_eq("evt_err_code", err_code, mon_e[109:108]);
        check_eq("evt_cfg_words", cfg_words, mon_e[107:0]);
        check_eq("evt_cfg_valid", cfg_valid, mon_e[112]);
        if (mon_e[116:113] != 4'd0) begin
          check_eq("evt_latency", cyc - last_bit_cyc, mon_e[116:113]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic word_illegal(input logic [5:0] w);
    logic [2:0] m;
    logic [2:0] idx;
    m   = w[2:0];
    idx = w[5:3];
    if (m == 3'd0) return 1'b0;
    if (m == 3'd1 || m == 3'd3) return idx >= 3'd5;
    if (m == 3'd2 || m == 3'd4) return idx >= 3'd4;
    return 1'b1;
  endfunction

  function automatic logic [7:0] frame_sum(input logic [107:0] w);
    int s = 0;
    for (int k = 0; k < 18; k++) s += int'(w[6*k +: 6]);
    return 8'(s % 256);
  endfunction

  function automatic logic [107:0] rand_frame();
    logic [107:0] w = '0;
    int m;
    int idx;
    for (int k = 0; k < 18; k++) begin
      m = $urandom_range(0, 4);
      if (m == 0) idx = $urandom_range(0, 7);
      else if (m == 1 || m == 3) idx = $urandom_range(0, 4);
      else idx = $urandom_range(0, 3);
      w[6*k +: 6] = {3'(idx), 3'(m)};
    end
    return w;
  endfunction

  task automatic expect_frame(input logic [107:0] w, input logic [7:0] chk);
    logic bad = 1'b0;
    for (int k = 0; k < 18; k++) bad |= word_illegal(w[6*k +: 6]);
    if (chk != frame_sum(w)) begin
      exp_q.push_back({4'd1, mdl_valid, 2'b01, 2'd1, mdl_words});
    end else if (bad) begin
      exp_q.push_back({4'd1, mdl_valid, 2'b01, 2'd2, mdl_words});
    end else begin
      mdl_words = w;
      mdl_valid = 1'b1;
      exp_q.push_back({4'd2, 1'b1, 2'b10, 2'd0, w});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b, input bit gap);
    @(negedge clk);
    cfg_en  = 1'b1;
    cfg_bit = b;
    if (gap) begin
      @(negedge clk);
      cfg_en = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_en  = 1'b0;
      cfg_bit = 1'b0;
    end
  endtask

  task automatic send_byte_msb(input logic [7:0] v, input bit gap);
    for (int i = 7; i >= 0; i--) drive_bit(v[i], gap);
  endtask

  task automatic send_payload(input logic [107:0] w, input int lo, input int hi, input bit gap);
    for (int i = lo; i <= hi; i++) drive_bit(w[i], gap);
  endtask

  task automatic send_chk(input logic [107:0] w, input logic [7:0] chk, input bit gap);
    for (int i = 0; i < 7; i++) drive_bit(chk[i], gap);
    @(negedge clk);
    cfg_en       = 1'b1;
    cfg_bit      = chk[7];
    last_bit_cyc = cyc;
    expect_frame(w, chk);
  endtask

  task automatic send_frame(input logic [107:0] w, input logic [7:0] chk, input bit gap);
    send_byte_msb(8'hA5, gap);
    send_payload(w, 0, 107, gap);
    send_chk(w, chk, gap);
  endtask

  // ---------------- stimulus ----------------
  logic [107:0] w1, w3, wr;

  initial begin
    rst       = 1'b1;
    cfg_en    = 1'b0;
    cfg_bit   = 1'b0;
    mdl_words = '0;
    mdl_valid = 1'b0;
    w1 = 108'h1A;
    w3 = 108'h24 << 30;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_cfg_words", cfg_words, 0);
    check_eq("rst_cfg_valid", cfg_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cfg_done", cfg_done, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_state", dbg_state, 0);

    // Basic commit, then busy drops.
    send_frame(w1, 8'h1A, 1'b0);
    idle(1);
    check_eq("commit_busy_in_commit", busy, 1);
    idle(3);
    check_eq("commit_busy_after", busy, 0);
    check_eq("commit_valid_after", cfg_valid, 1);

    // Bad checksum: err_code 1 must hold afterwards.
    send_frame(w1, 8'h1B, 1'b0);
    idle(6);
    check_eq("chk_err_code_hold", err_code, 1);
    check_eq("chk_err_pulse_gone", cfg_err, 0);

    // Range violation with otherwise correct checksum.
    send_frame(w3, 8'h24, 1'b0);
    idle(4);

    // Same frame as the first with cfg_en toggling every cycle.
    send_frame(w1, 8'h1A, 1'b1);
    idle(4);
    check_eq("toggle_err_code_cleared", err_code, 0);

    // Random legal frames, checksum wraps modulo 256.
    for (int n = 0; n < 4; n++) begin
      wr = rand_frame();
      send_frame(wr, frame_sum(wr), bit'($urandom_range(0, 1)));
      idle($urandom_range(1, 5));
    end

    // Timeout: 64 idle cycles after word 3.
    wr = rand_frame();
    send_byte_msb(8'hA5, 1'b0);
    send_payload(wr, 0, 23, 1'b0);
    exp_q.push_back({4'd0, mdl_valid, 2'b01, 2'd3, mdl_words});
    idle(66);
    check_eq("tmo_state", dbg_state, 0);
    check_eq("tmo_busy", busy, 0);
    check_eq("tmo_err_code", err_code, 3);

    // 63 idle cycles is tolerated; frame still commits.
    wr = rand_frame();
    send_byte_msb(8'hA5, 1'b0);
    send_payload(wr, 0, 23, 1'b0);
    idle(63);
    send_payload(wr, 24, 107, 1'b0);
    send_chk(wr, frame_sum(wr), 1'b0);
    idle(4);

    // Back-to-back: a bit during COMMIT is dropped, next sync starts right after.
    wr = rand_frame();
    send_frame(wr, frame_sum(wr), 1'b0);
    drive_bit(1'b1, 1'b0);
    wr = rand_frame();
    send_frame(wr, frame_sum(wr), 1'b0);
    idle(4);

    // Reset mid-PAYLOAD after a prior commit clears everything.
    wr = rand_frame();
    send_byte_msb(8'hA5, 1'b0);
    send_payload(wr, 0, 40, 1'b0);
    @(negedge clk);
    rst    = 1'b1;
    cfg_en = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    mdl_words = '0;
    mdl_valid = 1'b0;
    check_eq("midrst_cfg_words", cfg_words, 0);
    check_eq("midrst_cfg_valid", cfg_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_err_code", err_code, 0);
    check_eq("midrst_state", dbg_state, 0);
    send_frame(wr, frame_sum(wr), 1'b0);
    idle(4);

    // Noise byte 0xA4 must not sync; the following 0xA5 frame parses.
    send_byte_msb(8'hA4, 1'b0);
    wr = rand_frame();
    send_frame(wr, frame_sum(wr), 1'b0);
    idle(10);

    check_eq("pending_events", exp_q.size(), 0);
    check_eq("final_cfg_words", cfg_words, mdl_words);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switchbox_cfg_loader.md
Name: switchbox_cfg_loader

Overview:
- Configuration stage directly upstream of the switch-box routing matrix.
- Receives a serial configuration frame and validates it; on success, atomically commits the 18 six-bit route words that drive the matrix select registers.
- Words are ordered top[0..4], bottom[0..4], left[0..3], right[0..3].
- Each word is {index[5:3], mode[2:0]}: mode 0 = Z, 1 = top, 2 = right, 3 = bottom, 4 = left; index selects the pin on that side.

Parameters:
SYNC_PATTERN, 8'hA5, frame start marker
TIMEOUT_CYCLES, 64, max consecutive idle cycles (cfg_en low) tolerated inside a frame
NWORDS, 18, route words per frame (fixed; not for override)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cfg_en  input  1  cfg_bit is valid this cycle
cfg_bit  input  1  serial configuration data
cfg_words  output  108  active route words; word k at [6k+5:6k]
cfg_valid  output  1  high once any frame has committed
busy  output  1  high while not in HUNT
cfg_done  output  1  one-cycle pulse on successful commit
cfg_err  output  1  one-cycle pulse on rejected frame
err_code  output  2  1 checksum, 2 range, 3 timeout; holds until the next done/err

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - cfg_words = 0 (all pins Z); cfg_valid = 0, busy = 0, cfg_done = 0, cfg_err = 0, err_code = 0.
  - State = HUNT, sync window = 0, all counters = 0, shadow = 0.
- Reset mid-frame: discards the shadow; active words are also cleared to 0.
- Bits are consumed only on cycles with cfg_en = 1; cfg_en = 0 pauses without loss.
- States:
  - HUNT:
    - On each accepted bit: window <= {window[6:0], cfg_bit}.
    - If the new window value == SYNC_PATTERN: clear the bit counter, idle counter and running sum; go to PAYLOAD.
  - PAYLOAD:
    - Receives 108 bits, LSB first within each word, word 0 first.
    - Each completed word is written into shadow[k] and added to an 8-bit running sum (mod 256, word zero-extended).
    - Range flag is set if any word has mode 5..7, or mode 1/3 with index > 4, or mode 2/4 with index > 3.
    - Mode 0 words ignore the index.
    - After bit 107, go to CHECK.
  - CHECK:
    - Receives 8 checksum bits, LSB first.
    - On the 8th bit, evaluate in this order:
      1. Checksum != sum: cfg_err, err_code = 1.
      2. Else range flag set: cfg_err, err_code = 2.
      3. Else go to COMMIT.
    - On either error, return to HUNT.
  - COMMIT (one cycle):
    - cfg_words <= shadow, cfg_valid <= 1, cfg_done = 1, err_code <= 0.
    - Next state is HUNT.
    - Latency: cfg_words changes on the same clock edge cfg_done goes high, one cycle after the last checksum bit is sampled.
- Timeout:
  - In PAYLOAD or CHECK, the idle counter increments on each cfg_en = 0 cycle and clears on cfg_en = 1.
  - On reaching TIMEOUT_CYCLES: cfg_err, err_code = 3, return to HUNT.
- Rejected frames never alter cfg_words or cfg_valid.
- cfg_done and cfg_err are never asserted together.
- The sync window is cleared on entry to HUNT, so no sync detection can overlap the tail of the previous frame.
- cfg_en during COMMIT is ignored; the bit is dropped.
- Back-to-back frames: a new sync can start the cycle after COMMIT.
- busy = 1 in PAYLOAD, CHECK and COMMIT.

Test Plan:
- Reset, then sync 0xA5, then word0 = 6'h1A (mode 2, index 3) with the other 17 words 0, then checksum 0x1A -> cfg_done one cycle after the last bit; cfg_words[5:0] = 0x1A and the rest 0; cfg_valid = 1; busy returns to 0.
- Same frame but checksum 0x1B -> cfg_err, err_code = 1, cfg_words unchanged.
- Frame with word 5 (bottom[0]) = mode 4, index 4 (6'h24), correct checksum 0x24 -> cfg_err, err_code = 2, no commit.
- Valid frame with cfg_en toggled 1/0 every cycle -> identical commit to the first scenario.
- cfg_en held low for 64 cycles after word 3 -> cfg_err, err_code = 3, state HUNT.
- rst asserted mid-PAYLOAD after a prior commit -> all outputs 0 next cycle; a following valid frame commits normally.
- Noise 0xA4 followed by 0xA5 -> only the second byte triggers sync; the frame is then parsed correctly.
